// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Single-clock FIFO with a parametrised width and depth. Both sides use a
//   chip-select qualified request handshake. The FIFO provides programmable
//   almost-full and almost-empty flags, an occupancy count, and
//   overflow/underflow error pulses. It has an optional first-word-fall-through
//   read mode.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   wr_cs/wr_en   write request; data_in is stored when accepted
//   rd_cs/rd_en   read request
//   data_out      read data (registered when FWFT=0, head of queue when FWFT=1)
//   full/empty    occupancy at the limits
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy, 0..DEPTH
//   overflow      1-cycle pulse for a write attempted while full
//   underflow     1-cycle pulse for a read attempted while empty
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_cs,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_cs,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags, so a write while full or a read
  // while empty is dropped even when the other side moves in the same cycle.
  assign wr_acc = wr_cs & wr_en & ~full;
  assign rd_acc = rd_cs & rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Flags are computed from next-count so that they line up with count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= wr_cs & wr_en & full;
      underflow    <= rd_cs & rd_en & empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is always presented. It is meaningful only while empty=0.
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          wr_cs, wr_en, rd_cs, rd_en;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout_a, dout_b;
  logic          full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic          full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [CW-1:0] count_a, count_b;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst),
    .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
    .rd_cs(rd_cs), .rd_en(rd_en), .data_out(dout_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .count(count_a), .overflow(ovf_a), .underflow(udf_a)
  );

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst),
    .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
    .rd_cs(rd_cs), .rd_en(rd_en), .data_out(dout_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(count_b), .overflow(ovf_b), .underflow(udf_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference: a queue of stored words, plus the last word popped for the
  // registered-read instance.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_a   = '0;
  bit            exp_ovf = 1'b0;
  bit            exp_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_a", 32'(count_a), n);
    chk("full_a",  32'(full_a),  32'(n == DEPTH));
    chk("empty_a", 32'(empty_a), 32'(n == 0));
    chk("af_a",    32'(af_a),    32'(n >= AF));
    chk("ae_a",    32'(ae_a),    32'(n <= AE));
    chk("ovf_a",   32'(ovf_a),   32'(exp_ovf));
    chk("udf_a",   32'(udf_a),   32'(exp_udf));
    chk("dout_a",  32'(dout_a),  32'(exp_a));
    chk("count_b", 32'(count_b), n);
    chk("full_b",  32'(full_b),  32'(n == DEPTH));
    chk("empty_b", 32'(empty_b), 32'(n == 0));
    chk("af_b",    32'(af_b),    32'(n >= AF));
    chk("ae_b",    32'(ae_b),    32'(n <= AE));
    chk("ovf_b",   32'(ovf_b),   32'(exp_ovf));
    chk("udf_b",   32'(udf_b),   32'(exp_udf));
    if (n > 0) chk("dout_b", 32'(dout_b), 32'(q[0]));
  endtask

  // Drive one cycle of stimulus (called at a falling edge), advance the model
  // at the rising edge, and compare at the next falling edge.
  task automatic step(input bit wc, input bit we, input logic [DW-1:0] d,
                      input bit rc, input bit re);
    bit f, e, wa, ra;
    wr_cs = wc; wr_en = we; data_in = d; rd_cs = rc; rd_en = re;
    @(posedge clk);
    f  = (q.size() == DEPTH);
    e  = (q.size() == 0);
    wa = wc && we && !f;
    ra = rc && re && !e;
    exp_ovf = wc && we && f;
    exp_udf = rc && re && e;
    if (ra) exp_a = q.pop_front();
    if (wa) q.push_back(d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic rand_phase(input int cycles, input int wr_pct, input int rd_pct);
    for (int i = 0; i < cycles; i++) begin
      step($urandom_range(99) < 85, $urandom_range(99) < wr_pct, DW'($urandom),
           $urandom_range(99) < 85, $urandom_range(99) < rd_pct);
    end
  endtask

  initial begin
    wr_cs = 0; wr_en = 0; rd_cs = 0; rd_en = 0; data_in = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b1;
    idle();

    // Fill with 0x01..0x10; almost_full and full are checked every cycle.
    for (int i = 1; i <= DEPTH; i++) step(1, 1, DW'(i), 0, 0);

    // Writes while full: plain, masked by wr_cs, and alongside an accepted read.
    step(1, 1, 8'hAA, 0, 0);
    idle();
    step(0, 1, 8'hCC, 0, 0);
    step(1, 1, 8'hBB, 1, 1);
    step(1, 1, 8'h11, 0, 0);

    // Drain everything in order.
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1, 1);
    idle();

    // Reads while empty: plain, masked by rd_cs, and alongside an accepted write.
    step(0, 0, '0, 1, 1);
    idle();
    step(0, 0, '0, 0, 1);
    step(1, 1, 8'h77, 1, 1);
    step(0, 0, '0, 1, 1);
    idle();

    // Hold the count at 5 while streaming 40 words through.
    for (int i = 0; i < 5; i++) step(1, 1, DW'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, DW'($urandom), 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 1);

    // Single word into an empty FIFO, then popped.
    step(1, 1, 8'h5A, 0, 0);
    idle();
    step(0, 0, '0, 1, 1);

    // Random traffic biased toward filling, balanced, and draining.
    rand_phase(150, 75, 35);
    rand_phase(150, 50, 50);
    rand_phase(150, 30, 75);

    // Reset while partially full; flags must clear without waiting for a clock.
    for (int i = 0; i < 6; i++) step(1, 1, DW'($urandom), 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_empty_a", 32'(empty_a), 32'd1);
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_empty_b", 32'(empty_b), 32'd1);
    chk("rst_count_b", 32'(count_b), 32'd0);
    chk("rst_dout_a",  32'(dout_a),  32'd0);
    q.delete();
    exp_a = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, '0, 1, 1);
    step(1, 1, 8'h3C, 0, 0);
    step(0, 0, '0, 1, 1);
    rand_phase(100, 60, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
